// File: rtl/counter_pkg.sv
// Shared definitions for the counter load/check controller: default widths,
// the controller state encoding and the mismatch counter limits.
package counter_pkg;

    localparam int CNT_W_DEF = 10;
    localparam int LEN_W_DEF = 8;
    localparam int MCNT_W    = 16;

    localparam logic [MCNT_W-1:0] MCNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        CHECK = 2'd3
    } state_t;

    // Saturating increment used for the running mismatch count.
    function automatic logic [MCNT_W-1:0] sat_inc(input logic [MCNT_W-1:0] v);
        return (v == MCNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/run_timer.sv
// Run-length down-counter: armed by a one-cycle start strobe with len, then
// raises expire during the last of the len cycles that follow the strobe.
module run_timer #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             expire
);

    logic [LEN_W-1:0] rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
        end else if (start) begin
            rem <= len;
        end else if (rem != '0) begin
            rem <= rem - 1'b1;
        end
    end

    // rem counts len..1 across the run; a zero length never expires.
    assign expire = (rem == LEN_W'(1));

endmodule

// File: rtl/counter_load_ctrl.sv
// Loads a downstream counter, lets it run for len cycles, then checks its
// value against start+len and keeps a saturating count of failed checks.
module counter_load_ctrl
    import counter_pkg::*;
#(
    parameter int                CNT_W    = CNT_W_DEF,
    parameter int                LEN_W    = LEN_W_DEF,
    parameter logic [MCNT_W-1:0] MCNT_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CNT_W-1:0]  cmd_start,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              load,
    output logic [CNT_W-1:0]  load_count_value,
    input  logic [CNT_W-1:0]  count_in,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic [MCNT_W-1:0] mismatch_cnt
);

    state_t           state;
    logic [CNT_W-1:0] start_q;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] expected;
    logic             expire;
    logic             hit;

    // Wrap-around is intentional: the counter is CNT_W bits wide as well.
    assign expected  = start_q + CNT_W'(len_q);
    assign hit       = (count_in == expected);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    run_timer #(
        .LEN_W (LEN_W)
    ) u_run_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (state == LOAD),
        .len    (len_q),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            start_q          <= '0;
            len_q            <= '0;
            load             <= 1'b0;
            load_count_value <= '0;
            done             <= 1'b0;
            match            <= 1'b0;
            mismatch_cnt     <= MCNT_RST;
        end else begin
            load             <= 1'b0;
            load_count_value <= '0;
            done             <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        start_q          <= cmd_start;
                        len_q            <= cmd_len;
                        load             <= 1'b1;
                        load_count_value <= cmd_start;
                        state            <= LOAD;
                    end
                end
                LOAD: begin
                    state <= (len_q != '0) ? RUN : CHECK;
                end
                RUN: begin
                    if (expire) state <= CHECK;
                end
                CHECK: begin
                    // Result lands in the done cycle, which is also IDLE.
                    done  <= 1'b1;
                    match <= hit;
                    if (!hit) mismatch_cnt <= sat_inc(mismatch_cnt);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/counter_load_ctrl.md
COUNTER_LOAD_CTRL -- requirements
Module: counter_load_ctrl

Interface
REQ-001 Parameter CNT_W, default 10, width of count values.
REQ-002 Parameter LEN_W, default 8, width of run length.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  controller can accept a command.
REQ-008 cmd_start  input  CNT_W  value to load into the downstream counter.
REQ-009 cmd_len  input  LEN_W  number of increment cycles before the check.
REQ-010 load  output  1  load strobe to the counter.
REQ-011 load_count_value  output  CNT_W  load data to the counter.
REQ-012 count_in  input  CNT_W  counter output being checked.
REQ-013 busy  output  1  command in progress (any state other than IDLE).
REQ-014 done  output  1  one-cycle pulse when the check result is valid.
REQ-015 match  output  1  last check passed; valid while done is high, held until the next done.
REQ-016 mismatch_cnt  output  16  running count of failed checks, saturating.

Function
REQ-017 The FSM SHALL have four states: IDLE, LOAD, RUN, CHECK.
REQ-018 IDLE: cmd_ready=1; a transfer occurs on cmd_valid&&cmd_ready; it captures cmd_start and cmd_len and goes to LOAD.
REQ-019 LOAD lasts exactly one cycle: load=1, load_count_value=captured start; the counter takes start at the end of this cycle.
REQ-020 Outside LOAD: load=0 and load_count_value=0.
REQ-021 LOAD->RUN if len!=0; LOAD->CHECK if len==0.
REQ-022 RUN lasts exactly len cycles, counted by a down-counter; in the last RUN cycle the FSM goes to CHECK.
REQ-023 Expected value = (start + len) mod 2^CNT_W; CNT_W-bit wrap-around, no overflow flag.
REQ-024 CHECK lasts one cycle: it compares count_in with the expected value, registers the result into match, then goes to IDLE.
REQ-025 done=1 in the cycle after CHECK only; match is updated in the same cycle.
REQ-026 On mismatch, mismatch_cnt increments in the done cycle; it saturates at 0xFFFF.
REQ-027 cmd_ready=1 in the done cycle; a command accepted then SHALL enter LOAD next cycle (zero bubble).
REQ-028 cmd_valid outside IDLE is ignored; no buffering.
REQ-029 Total latency from accept to done = len+3 cycles.

Reset
REQ-030 On rst: state=IDLE, load=0, load_count_value=0, done=0, match=0, mismatch_cnt=0, busy=0, cmd_ready=1 from the cycle after rst deasserts.
REQ-031 rst in any state, including mid-RUN, SHALL abort the command with no done pulse; rst takes priority over cmd_valid.

Structure
REQ-032 Shared package counter_pkg SHALL hold CNT_W and LEN_W defaults and the state enum typedef (IDLE, LOAD, RUN, CHECK).
REQ-033 The run-length down-counter SHALL be a sub-module run_timer (inputs: start, len; outputs: expire).
REQ-034 Target size: 120-400 lines of RTL; no memories; single clock domain.

Verification
REQ-035 Start 100, len 150, paired with a correct 10-bit loadable counter -> load high exactly one cycle with value 100; done at accept+153; match=1; mismatch_cnt=0.
REQ-036 Start 1020, len 10 -> expected 6 (wrap); match=1.
REQ-037 Start 5, len 0 -> LOAD then CHECK; done at accept+3; match=1 with count_in=5.
REQ-038 Counter model forced to 1 less than expected -> match=0; mismatch_cnt increments by 1; counter preset near 0xFFFF saturates at 0xFFFF.
REQ-039 rst asserted during RUN (len 200, cycle 50) -> no done pulse, load=0, cmd_ready=1 after reset; next command completes normally.
REQ-040 cmd_valid held high continuously with 10 random start/len pairs -> back-to-back accepts in the done cycles, each done spaced len+3 cycles apart; all match=1.
